game_fsm: RTL

- Top-level game-flow controller for the flappy-bird design.
- Produces the 2-bit screen state consumed by the RGB menu multiplexer: start screen, game, game over.
- Sequences the game from the player button, and from collision, pipe-passed and frame-tick events supplied by the game logic.
- Owns the current score, the best score, and the flap and round-restart pulses.

---
 rtl/game_pkg.sv | 35 +++
 rtl/bcd_counter3.sv | 23 ++
 rtl/game_fsm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-flow types, BCD constants and saturating BCD increment
package game_pkg;

  typedef enum logic [1:0] {
    ST_START    = 2'b00,
    ST_GAME     = 2'b01,
    ST_GAMEOVER = 2'b10
  } game_state_t;

  typedef logic [11:0] bcd3_t;

  localparam bcd3_t BCD3_ZERO = 12'h000;
  localparam bcd3_t BCD3_MAX  = 12'h999;

  // Add one to a 3-digit BCD value, rippling the carry upward; 999 sticks at 999.
  function automatic bcd3_t bcd3_inc(input bcd3_t v);
    bcd3_t r;
    r = v;
    if (v != BCD3_MAX) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// rtl/bcd_counter3.sv - three-digit saturating BCD up-counter with synchronous clear
module bcd_counter3
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        inc,
  output logic [11:0] value
);

  // Clear wins over increment so a new round always starts from 000.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= BCD3_ZERO;
    end else if (clear) begin
      value <= BCD3_ZERO;
    end else if (inc) begin
      value <= bcd3_inc(value);
    end
  end

endmodule

// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - flappy-bird game-flow controller: screen state, score, best, flap and restart pulses
module game_fsm
  import game_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCKOUT_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  input  logic        collision,
  input  logic        pipe_passed,
  input  logic        frame_tick,
  output logic [1:0]  state,
  output logic        game_rst,
  output logic        flap,
  output logic [11:0] score,
  output logic [11:0] best,
  output logic        new_best
);

  localparam int LOCK_W = (LOCKOUT_FRAMES > 0) ? $clog2(LOCKOUT_FRAMES + 1) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_FRAMES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_dly_q;
  logic                   btn_rise;

  game_state_t            state_q;
  game_state_t            state_d;
  logic [LOCK_W-1:0]      lock_q;
  logic [LOCK_W-1:0]      lock_d;

  logic                   flap_d;
  logic                   game_rst_d;
  logic                   score_clear;
  logic                   score_inc;
  logic                   best_load;
  logic                   new_best_clear;

  // Bring the raw button into the clock domain and keep one extra sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      btn_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn};
      btn_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign btn_rise = sync_q[SYNC_STAGES-1] & ~btn_dly_q;

  // Screen state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next screen: button starts or leaves a round, collision ends it; unknown codes fall back to START.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START:    if (btn_rise) state_d = ST_GAME;
      ST_GAME:     if (collision) state_d = ST_GAMEOVER;
      ST_GAMEOVER: if (btn_rise && (lock_q == '0)) state_d = ST_START;
      default:     state_d = ST_START;
    endcase
  end

  // Per-state actions; collision takes priority over flap and scoring in the same cycle.
  always_comb begin
    flap_d         = 1'b0;
    game_rst_d     = 1'b0;
    score_clear    = 1'b0;
    score_inc      = 1'b0;
    best_load      = 1'b0;
    new_best_clear = 1'b0;
    lock_d         = lock_q;
    case (state_q)
      ST_START: begin
        if (btn_rise) begin
          flap_d         = 1'b1;
          game_rst_d     = 1'b1;
          score_clear    = 1'b1;
          new_best_clear = 1'b1;
        end
      end
      ST_GAME: begin
        if (collision) begin
          lock_d    = LOCK_LOAD;
          best_load = (score > best);
        end else begin
          flap_d    = btn_rise;
          score_inc = pipe_passed;
        end
      end
      ST_GAMEOVER: begin
        if (frame_tick && (lock_q != '0)) begin
          lock_d = lock_q - LOCK_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered pulses, lockout counter and best-score bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flap     <= 1'b0;
      game_rst <= 1'b0;
      lock_q   <= '0;
      best     <= BCD3_ZERO;
      new_best <= 1'b0;
    end else begin
      flap     <= flap_d;
      game_rst <= game_rst_d;
      lock_q   <= lock_d;
      if (best_load) begin
        best     <= score;
        new_best <= 1'b1;
      end else if (new_best_clear) begin
        new_best <= 1'b0;
      end
    end
  end

  assign state = state_q;

  bcd_counter3 u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (score_clear),
    .inc   (score_inc),
    .value (score)
  );

endmodule
